reg_write_queue: RTL and testbench
==================================

# reg_write_queue

Write-side front end of the 32-entry register file. Accepts results from two producers (single-cycle ALU path and multi-cycle load/mul path) over valid/ready handshakes, buffers them in a small in-order FIFO, and drains at most one entry per cycle into the register file write port (WRITE_ENABLE / WRITE_ADDRESS / WRITE_DATA). Also exports a pending-write scoreboard and an optional forwarding lookup for the operand-fetch stage.

## Interface
- DEPTH, 4, FIFO entries; power of two, >= 2
- DATA_WIDTH, 32, result width
- ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH registers)
- CLK  input  1  clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- A_VALID / A_ADDRESS / A_DATA  input  1 / ADDR_WIDTH / DATA_WIDTH  port A (ALU) request
- A_READY  output  1  port A accepted this cycle
- B_VALID / B_ADDRESS / B_DATA  input  1 / ADDR_WIDTH / DATA_WIDTH  port B (load/mul) request
- B_READY  output  1  port B accepted this cycle
- HOLD  input  1  stalls draining; WRITE_ENABLE forced 0
- WRITE_ENABLE / WRITE_ADDRESS / WRITE_DATA  output  1 / ADDR_WIDTH / DATA_WIDTH  to register file write port
- PENDING  output  2**ADDR_WIDTH  bit r = 1 while any queued entry targets register r
- RD_ADDRESS  input  ADDR_WIDTH  forwarding lookup address
- RD_HIT / RD_DATA  output  1 / DATA_WIDTH  forwarding result
- COUNT  output  log2(DEPTH)+1  current occupancy

## Operation
- At most one enqueue per cycle. Grant when FIFO not full (COUNT < DEPTH, from registered state only; no same-cycle dequeue credit).
- Arbitration: one requester -> it is granted. Both valid -> round-robin: grant the port not granted last time both competed; rr bit resets to favour A.
- X_READY = grant to X; transfer occurs when X_VALID && X_READY at rising edge.
- Address 0: transfer is accepted (READY=1 if granted) but no entry is enqueued; COUNT, PENDING unchanged.
- Drain: WRITE_ENABLE = !empty && !HOLD && !RESET; WRITE_ADDRESS/WRITE_DATA = head entry (0 when empty). Head pops at the edge where WRITE_ENABLE = 1.
- Simultaneous enqueue and dequeue: both happen; COUNT unchanged. Entries retire strictly in enqueue order, including repeated writes to the same register.
- PENDING: OR over valid entries of one-hot(address); combinational from state.
- Forwarding (see Configuration): RD_HIT = 1 if any valid entry has address == RD_ADDRESS != 0; RD_DATA = data of youngest such entry, else 0.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (RESET high at edge): FIFO emptied, pointers and COUNT = 0, rr bit = A. While RESET high: A_READY = B_READY = 0, WRITE_ENABLE = 0. After reset all outputs 0.
- Reset mid-operation: all queued entries discarded, no write issued at that edge.
- Latency: entry accepted at edge N is visible on WRITE_* during cycle N+1 (if FIFO was empty and HOLD low); written at edge N+1. PENDING bit sets in cycle N+1, clears in cycle after its write edge.
- Full: READY = 0 on both ports until a pop edge; earliest re-grant is the cycle after the pop.
- Throughput: sustained 1 entry/cycle in and out.

## Configuration
- REG_WRITE_QUEUE_FWD_EN defined: forwarding lookup active as above.
- Undefined: RD_HIT and RD_DATA tied 0; lookup logic not built; ports remain present.

## Test plan
- Reset: hold RESET 2 cycles with A_VALID=1 -> A_READY=0, WRITE_ENABLE=0, COUNT=0, PENDING=0.
- Single write: A writes x5=0xDEADBEEF at edge 1 -> cycle 2 WRITE_ENABLE=1, ADDR=5, DATA=0xDEADBEEF, PENDING[5]=1; cycle 3 PENDING=0, COUNT=0.
- Round-robin: A and B both valid 4 cycles with HOLD=1, DEPTH=4 -> grants A,B,A,B; 5th cycle both READY=0; release HOLD -> drain order A0,B0,A1,B1.
- Address 0: B writes x0=0x1234 -> B_READY=1, COUNT stays 0, no WRITE_ENABLE.
- Forwarding (macro on): queue x7=0x11 then x7=0x22 with HOLD=1, RD_ADDRESS=7 -> RD_HIT=1, RD_DATA=0x22; RD_ADDRESS=0 -> RD_HIT=0. Macro off -> RD_HIT=0.
- Reset mid-queue: 3 entries queued, HOLD=1, pulse RESET -> COUNT=0, PENDING=0, no writes ever issued for those entries.

Source files
------------

// File: rtl/reg_write_queue_if.sv
// reg_write_queue_if: groups the producer handshakes, the register file write
// port, the pending-write scoreboard, the forwarding lookup and the occupancy
// count of reg_write_queue.
// The slave modport is the queue side and the master modport is the
// producer/consumer side.
interface reg_write_queue_if #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                      A_VALID;
   logic [ADDR_WIDTH-1:0]     A_ADDRESS;
   logic [DATA_WIDTH-1:0]     A_DATA;
   logic                      A_READY;

   logic                      B_VALID;
   logic [ADDR_WIDTH-1:0]     B_ADDRESS;
   logic [DATA_WIDTH-1:0]     B_DATA;
   logic                      B_READY;

   logic                      HOLD;

   logic                      WRITE_ENABLE;
   logic [ADDR_WIDTH-1:0]     WRITE_ADDRESS;
   logic [DATA_WIDTH-1:0]     WRITE_DATA;

   logic [(2**ADDR_WIDTH)-1:0] PENDING;

   logic [ADDR_WIDTH-1:0]     RD_ADDRESS;
   logic                      RD_HIT;
   logic [DATA_WIDTH-1:0]     RD_DATA;

   logic [$clog2(DEPTH):0]    COUNT;

   modport slave (
      input  A_VALID, A_ADDRESS, A_DATA,
      output A_READY,
      input  B_VALID, B_ADDRESS, B_DATA,
      output B_READY,
      input  HOLD,
      output WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA,
      output PENDING,
      input  RD_ADDRESS,
      output RD_HIT, RD_DATA,
      output COUNT
   );

   modport master (
      output A_VALID, A_ADDRESS, A_DATA,
      input  A_READY,
      output B_VALID, B_ADDRESS, B_DATA,
      input  B_READY,
      output HOLD,
      input  WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA,
      input  PENDING,
      output RD_ADDRESS,
      input  RD_HIT, RD_DATA,
      input  COUNT
   );
endinterface

// File: rtl/reg_write_queue.sv
// reg_write_queue: write-side front end of the register file.
// It takes results from two producers (port A is the ALU and port B is
// load/mul), arbitrating round-robin between them. It buffers the results in
// an in-order FIFO and drains at most one entry per cycle into the register
// file write port.
// It also exports a pending-write scoreboard.
// Optional feature macro: REG_WRITE_QUEUE_FWD_EN builds the forwarding lookup
// (RD_HIT/RD_DATA). When the macro is undefined, both outputs are tied to 0.
module reg_write_queue #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                 CLK,
   input  logic                 RESET,
   reg_write_queue_if.slave     bus
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   logic [ADDR_WIDTH-1:0] entry_addr [DEPTH];
   logic [DATA_WIDTH-1:0] entry_data [DEPTH];

   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [CNT_W-1:0]      count;
   logic                  rr_favor_b;

   logic                  full;
   logic                  empty;
   logic                  grant_a;
   logic                  grant_b;
   logic                  push;
   logic                  pop;
   logic [ADDR_WIDTH-1:0] push_addr;
   logic [DATA_WIDTH-1:0] push_data;
   logic [NUM_REGS-1:0]   pending;
   logic [PTR_W-1:0]      pend_idx;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // Grant at most one producer per cycle, based only on the registered
   // occupancy. When both producers compete, the port that lost last time wins.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!RESET && !full) begin
         if (bus.A_VALID && bus.B_VALID) begin
            if (rr_favor_b) begin
               grant_b = 1'b1;
            end else begin
               grant_a = 1'b1;
            end
         end else if (bus.A_VALID) begin
            grant_a = 1'b1;
         end else if (bus.B_VALID) begin
            grant_b = 1'b1;
         end
      end
   end

   assign push_addr = grant_b ? bus.B_ADDRESS : bus.A_ADDRESS;
   assign push_data = grant_b ? bus.B_DATA    : bus.A_DATA;
   // Writes to x0 are handshaken but dropped, because x0 is hard-wired to zero.
   assign push      = (grant_a || grant_b) && (push_addr != '0);
   assign pop       = !empty && !bus.HOLD && !RESET;

   assign bus.A_READY       = grant_a;
   assign bus.B_READY       = grant_b;
   assign bus.WRITE_ENABLE  = pop;
   assign bus.WRITE_ADDRESS = empty ? '0 : entry_addr[rd_ptr];
   assign bus.WRITE_DATA    = empty ? '0 : entry_data[rd_ptr];
   assign bus.COUNT         = count;
   assign bus.PENDING       = pending;

   // Entry storage needs no reset, because the pointers and count decide
   // which entries are live.
   always_ff @(posedge CLK) begin
      if (push) begin
         entry_addr[wr_ptr] <= push_addr;
         entry_data[wr_ptr] <= push_data;
      end
   end

   // Pointers, occupancy and the round-robin bit. Reset discards every queued
   // entry and makes port A the favoured port again.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         rr_favor_b <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (bus.A_VALID && bus.B_VALID && (grant_a || grant_b)) begin
            rr_favor_b <= grant_a;
         end
      end
   end

   // Scoreboard: set one bit for the target register of every live entry.
   always_comb begin
      pending  = '0;
      pend_idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         pend_idx = rd_ptr + PTR_W'(k);
         if (CNT_W'(k) < count) begin
            pending[entry_addr[pend_idx]] = 1'b1;
         end
      end
   end

`ifdef REG_WRITE_QUEUE_FWD_EN
   logic                  fwd_hit;
   logic [DATA_WIDTH-1:0] fwd_data;
   logic [PTR_W-1:0]      fwd_idx;

   // Scan the entries from oldest to youngest so that the youngest matching
   // entry is the one that supplies the forwarded data.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx = rd_ptr + PTR_W'(k);
         if ((CNT_W'(k) < count) && (bus.RD_ADDRESS != '0) &&
             (entry_addr[fwd_idx] == bus.RD_ADDRESS)) begin
            fwd_hit  = 1'b1;
            fwd_data = entry_data[fwd_idx];
         end
      end
   end

   assign bus.RD_HIT  = fwd_hit;
   assign bus.RD_DATA = fwd_data;
`else
   assign bus.RD_HIT  = 1'b0;
   assign bus.RD_DATA = '0;
`endif

endmodule

// File: tb/tb_reg_write_queue.sv
// tb_reg_write_queue: directed testbench for reg_write_queue, with
// hand-computed expected values.
// The forwarding expectations follow REG_WRITE_QUEUE_FWD_EN.
module tb_reg_write_queue;

   localparam int DEPTH      = 4;
   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;

`ifdef REG_WRITE_QUEUE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk;
   logic reset;
   int   assert_count;
   int   fail_count;

   reg_write_queue_if #(
      .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
   ) bus ();

   reg_write_queue #(
      .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
   ) dut (
      .CLK   (clk),
      .RESET (reset),
      .bus   (bus.slave)
   );

   // Free-running clock with a 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      assert_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitEdge();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic a_v, input logic [4:0] a_a, input logic [31:0] a_d,
                                input logic b_v, input logic [4:0] b_a, input logic [31:0] b_d,
                                input logic hold);
      bus.A_VALID   = a_v;
      bus.A_ADDRESS = a_a;
      bus.A_DATA    = a_d;
      bus.B_VALID   = b_v;
      bus.B_ADDRESS = b_a;
      bus.B_DATA    = b_d;
      bus.HOLD      = hold;
      #1;
   endtask

   logic [4:0]  a_addr_seq [3];
   logic [31:0] a_data_seq [3];
   logic [4:0]  b_addr_seq [2];
   logic [31:0] b_data_seq [2];
   logic [4:0]  drain_addr [5];
   logic [31:0] drain_data [5];
   logic [4:0]  exp_count  [5];
   logic        exp_grant_a [4];
   int          ai;
   int          bi;

   initial begin
      assert_count = 0;
      fail_count   = 0;
      a_addr_seq = '{5'd1, 5'd3, 5'd6};
      a_data_seq = '{32'hAAAA_0000, 32'hAAAA_0001, 32'hAAAA_0002};
      b_addr_seq = '{5'd2, 5'd4};
      b_data_seq = '{32'hBBBB_0000, 32'hBBBB_0001};
      drain_addr = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6};
      drain_data = '{32'hAAAA_0000, 32'hBBBB_0000, 32'hAAAA_0001, 32'hBBBB_0001, 32'hAAAA_0002};
      exp_count  = '{5'd4, 5'd3, 5'd3, 5'd2, 5'd1};
      exp_grant_a = '{1'b1, 1'b0, 1'b1, 1'b0};
      bus.RD_ADDRESS = '0;

      // Reset held for two cycles while A requests.
      reset = 1'b1;
      applyStimulus(1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0);
      for (int c = 0; c < 2; c++) begin
         waitEdge();
         checkOutput("reset_a_ready", 64'(bus.A_READY), 64'd0);
         checkOutput("reset_we", 64'(bus.WRITE_ENABLE), 64'd0);
         checkOutput("reset_count", 64'(bus.COUNT), 64'd0);
         checkOutput("reset_pending", 64'(bus.PENDING), 64'd0);
      end
      reset = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
      checkOutput("idle_waddr", 64'(bus.WRITE_ADDRESS), 64'd0);
      checkOutput("idle_wdata", 64'(bus.WRITE_DATA), 64'd0);
      checkOutput("idle_rd_hit", 64'(bus.RD_HIT), 64'd0);

      // Single write of x5 = 0xDEADBEEF from port A.
      applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0);
      checkOutput("single_a_ready", 64'(bus.A_READY), 64'd1);
      checkOutput("single_b_ready", 64'(bus.B_READY), 64'd0);
      waitEdge();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
      checkOutput("single_we", 64'(bus.WRITE_ENABLE), 64'd1);
      checkOutput("single_waddr", 64'(bus.WRITE_ADDRESS), 64'd5);
      checkOutput("single_wdata", 64'(bus.WRITE_DATA), 64'hDEAD_BEEF);
      checkOutput("single_pending", 64'(bus.PENDING), 64'h20);
      checkOutput("single_count", 64'(bus.COUNT), 64'd1);
      waitEdge();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
      checkOutput("single_pending_clr", 64'(bus.PENDING), 64'd0);
      checkOutput("single_count_clr", 64'(bus.COUNT), 64'd0);
      checkOutput("single_we_clr", 64'(bus.WRITE_ENABLE), 64'd0);

      // Round-robin fill with HOLD: the grants alternate A,B,A,B.
      ai = 0;
      bi = 0;
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b1, a_addr_seq[ai], a_data_seq[ai],
                       1'b1, b_addr_seq[bi], b_data_seq[bi], 1'b1);
         checkOutput($sformatf("rr_a_ready_%0d", c), 64'(bus.A_READY), 64'(exp_grant_a[c]));
         checkOutput($sformatf("rr_b_ready_%0d", c), 64'(bus.B_READY), 64'(!exp_grant_a[c]));
         checkOutput($sformatf("rr_hold_we_%0d", c), 64'(bus.WRITE_ENABLE), 64'd0);
         if (exp_grant_a[c]) ai++;
         else bi++;
         waitEdge();
      end
      applyStimulus(1'b1, a_addr_seq[2], a_data_seq[2], 1'b1, b_addr_seq[1], b_data_seq[1], 1'b1);
      checkOutput("full_a_ready", 64'(bus.A_READY), 64'd0);
      checkOutput("full_b_ready", 64'(bus.B_READY), 64'd0);
      checkOutput("full_count", 64'(bus.COUNT), 64'd4);
      checkOutput("full_pending", 64'(bus.PENDING), 64'h1E);
      waitEdge();

      // Drain in enqueue order. A keeps requesting and is re-granted only
      // in the cycle after the first pop.
      for (int k = 0; k < 5; k++) begin
         if (k < 2) applyStimulus(1'b1, 5'd6, 32'hAAAA_0002, 1'b0, 5'd0, 32'h0, 1'b0);
         else       applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
         checkOutput($sformatf("drain_we_%0d", k), 64'(bus.WRITE_ENABLE), 64'd1);
         checkOutput($sformatf("drain_waddr_%0d", k), 64'(bus.WRITE_ADDRESS), 64'(drain_addr[k]));
         checkOutput($sformatf("drain_wdata_%0d", k), 64'(bus.WRITE_DATA), 64'(drain_data[k]));
         checkOutput($sformatf("drain_count_%0d", k), 64'(bus.COUNT), 64'(exp_count[k]));
         if (k == 0) checkOutput("drain_full_a_ready", 64'(bus.A_READY), 64'd0);
         if (k == 1) checkOutput("drain_regrant_a_ready", 64'(bus.A_READY), 64'd1);
         waitEdge();
      end
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
      checkOutput("drained_we", 64'(bus.WRITE_ENABLE), 64'd0);
      checkOutput("drained_count", 64'(bus.COUNT), 64'd0);
      checkOutput("drained_pending", 64'(bus.PENDING), 64'd0);
      checkOutput("drained_waddr", 64'(bus.WRITE_ADDRESS), 64'd0);
      checkOutput("drained_wdata", 64'(bus.WRITE_DATA), 64'd0);

      // Address 0 from port B is accepted but dropped.
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, 1'b0);
      checkOutput("x0_b_ready", 64'(bus.B_READY), 64'd1);
      waitEdge();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
      checkOutput("x0_count", 64'(bus.COUNT), 64'd0);
      checkOutput("x0_we", 64'(bus.WRITE_ENABLE), 64'd0);
      checkOutput("x0_pending", 64'(bus.PENDING), 64'd0);

      // Forwarding: the youngest write to x7 wins.
      applyStimulus(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 32'h0, 1'b1);
      checkOutput("fwd_a_ready0", 64'(bus.A_READY), 64'd1);
      waitEdge();
      applyStimulus(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'h0, 1'b1);
      waitEdge();
      bus.RD_ADDRESS = 5'd7;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
      checkOutput("fwd_count", 64'(bus.COUNT), 64'd2);
      checkOutput("fwd_pending", 64'(bus.PENDING), 64'h80);
      checkOutput("fwd_hit_x7", 64'(bus.RD_HIT), 64'(FWD));
      checkOutput("fwd_data_x7", 64'(bus.RD_DATA), FWD ? 64'h22 : 64'h0);
      bus.RD_ADDRESS = 5'd0;
      #1;
      checkOutput("fwd_hit_x0", 64'(bus.RD_HIT), 64'd0);
      checkOutput("fwd_data_x0", 64'(bus.RD_DATA), 64'd0);
      bus.RD_ADDRESS = 5'd9;
      #1;
      checkOutput("fwd_miss_x9", 64'(bus.RD_HIT), 64'd0);

      // Third entry, then a reset pulse discards the whole queue.
      applyStimulus(1'b1, 5'd9, 32'h33, 1'b0, 5'd0, 32'h0, 1'b1);
      waitEdge();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
      checkOutput("mid_count", 64'(bus.COUNT), 64'd3);
      checkOutput("mid_pending", 64'(bus.PENDING), 64'h280);
      checkOutput("mid_fwd_x9", 64'(bus.RD_DATA), FWD ? 64'h33 : 64'h0);
      reset = 1'b1;
      applyStimulus(1'b1, 5'd5, 32'h44, 1'b0, 5'd0, 32'h0, 1'b0);
      checkOutput("mid_reset_we", 64'(bus.WRITE_ENABLE), 64'd0);
      checkOutput("mid_reset_a_ready", 64'(bus.A_READY), 64'd0);
      waitEdge();
      reset = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
      checkOutput("post_reset_count", 64'(bus.COUNT), 64'd0);
      checkOutput("post_reset_pending", 64'(bus.PENDING), 64'd0);
      checkOutput("post_reset_we", 64'(bus.WRITE_ENABLE), 64'd0);
      checkOutput("post_reset_rd_hit", 64'(bus.RD_HIT), 64'd0);
      waitEdge();
      checkOutput("post_reset_we2", 64'(bus.WRITE_ENABLE), 64'd0);

      // After reset, port A is favoured when both ports compete.
      applyStimulus(1'b1, 5'd10, 32'h66, 1'b1, 5'd11, 32'h77, 1'b1);
      checkOutput("post_reset_rr_a", 64'(bus.A_READY), 64'd1);
      checkOutput("post_reset_rr_b", 64'(bus.B_READY), 64'd0);
      waitEdge();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
      checkOutput("final_waddr", 64'(bus.WRITE_ADDRESS), 64'd10);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
